fir_delay_line: RTL and testbench

- Parametrised successor to the fixed 40-tap, 3-bit, 4-group FIR delay chain.
- Input register loads a new sample on iEnDelay. The tap line shifts one position on each iEnSample600k.
- Taps are exported as a flat bus, split into equal groups for the parallel MAC slices.
- Adds beyond the fixed chain: synchronous flush, fill tracking (oFillCnt/oFull) and a registered shift-done strobe. The FIR controller uses these to suppress output until the line is primed.

---
 rtl/fir_delay_pkg.sv | 14 +
 rtl/delay_group.sv | 52 +++++
 rtl/fir_delay_line.sv | 83 ++++++++
 tb/tb_fir_delay_line.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_delay_pkg.sv
// fir_delay_pkg: default geometry of the FIR tap line.
// Shared by the tap line top and its group slices.
package fir_delay_pkg;

  localparam int FIR_IN_W   = 3;
  localparam int FIR_TAPS   = 40;
  localparam int FIR_GROUPS = 4;

  // A one-tap line still needs a 1-bit counter port.
  function automatic int cntWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/delay_group.sv
// delay_group: one equal-length slice of the FIR tap line.
// HEAD_IN makes the first tap the carry-in itself (group 0).
module delay_group #(
  parameter int WIDTH     = 3,
  parameter int GROUP_LEN = 10,
  parameter bit HEAD_IN   = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       shift,
  input  logic [WIDTH-1:0]           carryIn,
  output logic [GROUP_LEN*WIDTH-1:0] tapBus,
  output logic [WIDTH-1:0]           carryOut
);

  localparam int OFS  = HEAD_IN ? 1 : 0;
  localparam int NREG = GROUP_LEN - OFS;

  if (NREG == 0) begin : g_pass
    logic unusedCtl;
    assign unusedCtl = ^{clk, rst, flush, shift};
    assign tapBus = carryIn;
  end else begin : g_chain
    logic [WIDTH-1:0] stage [NREG];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < NREG; i++)
          stage[i] <= '0;
      end else if (flush) begin
        for (int i = 0; i < NREG; i++)
          stage[i] <= '0;
      end else if (shift) begin
        stage[0] <= carryIn;
        for (int i = 1; i < NREG; i++)
          stage[i] <= stage[i-1];
      end
    end

    for (genvar j = 0; j < GROUP_LEN; j++) begin : g_tap
      if (j < OFS) begin : g_head
        assign tapBus[j*WIDTH +: WIDTH] = carryIn;
      end else begin : g_reg
        assign tapBus[j*WIDTH +: WIDTH] = stage[j-OFS];
      end
    end
  end

  assign carryOut = tapBus[GROUP_LEN*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/fir_delay_line.sv
// fir_delay_line: parametrised FIR tap line with flush,
// fill tracking and a registered shift-done strobe.
module fir_delay_line
  import fir_delay_pkg::*;
#(
  parameter int  WIDTH      = FIR_IN_W,
  parameter int  DEPTH      = FIR_TAPS,
  parameter int  NUM_GROUPS = FIR_GROUPS,
  localparam int GROUP_LEN  = DEPTH / NUM_GROUPS,
  localparam int CNT_W      = cntWidth(DEPTH)
) (
  input  logic                   iClk12M,
  input  logic                   iRst,
  input  logic                   iEnSample600k,
  input  logic                   iEnDelay,
  input  logic                   iFlush,
  input  logic [WIDTH-1:0]       iFirIn,
  output logic [DEPTH*WIDTH-1:0] oDelayBus,
  output logic [CNT_W-1:0]       oFillCnt,
  output logic                   oFull,
  output logic                   oShiftDone
);

  if (DEPTH % NUM_GROUPS != 0) begin : g_badCfg
    $error("DEPTH must be a multiple of NUM_GROUPS");
  end

  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH - 1);

  logic [WIDTH-1:0]              rTap0;
  logic                          rLoaded;
  logic [CNT_W-1:0]              rFillCnt;
  logic                          rShiftDone;
  logic [NUM_GROUPS:0][WIDTH-1:0] carry;
  logic [WIDTH-1:0]              unusedTail;

  // Fill only counts shifts once a real sample sits in tap 0.
  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      rTap0      <= '0;
      rLoaded    <= 1'b0;
      rFillCnt   <= '0;
      rShiftDone <= 1'b0;
    end else if (iFlush) begin
      rTap0      <= '0;
      rLoaded    <= 1'b0;
      rFillCnt   <= '0;
      rShiftDone <= 1'b0;
    end else begin
      if (iEnDelay) begin
        rTap0   <= iFirIn;
        rLoaded <= 1'b1;
      end
      if (iEnSample600k && rLoaded && rFillCnt != FILL_MAX)
        rFillCnt <= rFillCnt + CNT_W'(1);
      rShiftDone <= iEnSample600k;
    end
  end

  assign carry[0] = rTap0;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
    delay_group #(
      .WIDTH     (WIDTH),
      .GROUP_LEN (GROUP_LEN),
      .HEAD_IN   (g == 0)
    ) u_group (
      .clk      (iClk12M),
      .rst      (iRst),
      .flush    (iFlush),
      .shift    (iEnSample600k),
      .carryIn  (carry[g]),
      .tapBus   (oDelayBus[g*GROUP_LEN*WIDTH +: GROUP_LEN*WIDTH]),
      .carryOut (carry[g+1])
    );
  end

  assign unusedTail = carry[NUM_GROUPS];
  assign oFillCnt   = rFillCnt;
  assign oFull      = rLoaded & (rFillCnt == FILL_MAX);
  assign oShiftDone = rShiftDone;

endmodule

// File: tb/tb_fir_delay_line.sv
// tb_fir_delay_line: random and directed checks of two line
// geometries against an array-based reference model.
module tb_fir_delay_line;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dlyA = 0, shA = 0, flA = 0;
  logic dlyB = 0, shB = 0, flB = 0;
  logic [2:0]   inA = '0;
  logic [7:0]   inB = '0;
  logic [119:0] busA;
  logic [95:0]  busB;
  logic [5:0]   cntA;
  logic [3:0]   cntB;
  logic fullA, doneA, fullB, doneB;

  int errs = 0;
  int checks = 0;

  int mTap [2][40];
  int mCnt [2];
  bit mLd [2];
  bit mDone [2];
  int dep [2] = '{40, 12};
  int msk [2] = '{7, 255};

  always #5 clk = ~clk;

  fir_delay_line dutA (
    .iClk12M(clk), .iRst(rst), .iEnSample600k(shA),
    .iEnDelay(dlyA), .iFlush(flA), .iFirIn(inA),
    .oDelayBus(busA), .oFillCnt(cntA), .oFull(fullA),
    .oShiftDone(doneA)
  );

  fir_delay_line #(.WIDTH(8), .DEPTH(12), .NUM_GROUPS(3)) dutB (
    .iClk12M(clk), .iRst(rst), .iEnSample600k(shB),
    .iEnDelay(dlyB), .iFlush(flB), .iFirIn(inB),
    .oDelayBus(busB), .oFillCnt(cntB), .oFull(fullB),
    .oShiftDone(doneB)
  );

  task automatic resetModel();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 40; k++) mTap[d][k] = 0;
      mCnt[d] = 0; mLd[d] = 0; mDone[d] = 0;
    end
  endtask

  // One clock edge of the line, from pre-edge state.
  task automatic modelEdge(input int id, input bit ld, sh, fl,
                           input int din);
    if (fl) begin
      for (int k = 0; k < 40; k++) mTap[id][k] = 0;
      mCnt[id] = 0; mLd[id] = 0; mDone[id] = 0;
    end else begin
      if (sh) begin
        for (int k = dep[id] - 1; k > 0; k--)
          mTap[id][k] = mTap[id][k-1];
        if (mLd[id] && mCnt[id] < dep[id] - 1) mCnt[id]++;
      end
      if (ld) begin
        mTap[id][0] = din & msk[id];
        mLd[id] = 1;
      end
      mDone[id] = sh;
    end
  endtask

  function automatic logic [119:0] expBusA();
    logic [119:0] b = '0;
    for (int k = 0; k < 40; k++) b[k*3 +: 3] = 3'(mTap[0][k]);
    return b;
  endfunction

  function automatic logic [95:0] expBusB();
    logic [95:0] b = '0;
    for (int k = 0; k < 12; k++) b[k*8 +: 8] = 8'(mTap[1][k]);
    return b;
  endfunction

  function automatic bit expFull(input int id);
    return mLd[id] && (mCnt[id] == dep[id] - 1);
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic step(input int id, input bit ld, sh, fl,
                      input int din);
    if (id == 0) begin
      dlyA = ld; shA = sh; flA = fl; inA = din[2:0];
    end else begin
      dlyB = ld; shB = sh; flB = fl; inB = din[7:0];
    end
    @(posedge clk);
    modelEdge(id, ld, sh, fl, din);
    modelEdge(1 - id, 0, 0, 0, 0);
    @(negedge clk);
    dlyA = 0; shA = 0; flA = 0;
    dlyB = 0; shB = 0; flB = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (busA !== '0) begin errs++;
      $display("FAIL rst_busA: got %h want 0", busA); end
    checks++; if (cntA !== '0 || fullA !== 1'b0) begin errs++;
      $display("FAIL rst_statA: got %0d/%0b want 0/0", cntA, fullA); end
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    step(0, 1, 0, 0, 5);
    step(1, 1, 1, 0, 200);
    step(0, 1, 1, 0, 6);
    #2 rst = 1'b1;
    #1;
    checks++; if (busA !== '0) begin errs++;
      $display("FAIL midrst_busA: got %h want 0", busA); end
    checks++; if (cntA !== '0) begin errs++;
      $display("FAIL midrst_cntA: got %0d want 0", cntA); end
    checks++; if (fullA !== 1'b0) begin errs++;
      $display("FAIL midrst_fullA: got %0b want 0", fullA); end
    checks++; if (doneA !== 1'b0) begin errs++;
      $display("FAIL midrst_doneA: got %0b want 0", doneA); end
    checks++; if (busB !== '0 || doneB !== 1'b0) begin errs++;
      $display("FAIL midrst_B: got %h/%0b want 0/0", busB, doneB); end
    @(negedge clk);
    rst = 1'b0;
    resetModel();
  endtask

  task automatic test_load_shift();
    step(0, 1, 0, 0, 3);
    checks++; if (busA[2:0] !== 3'd3 || doneA !== 1'b0) begin errs++;
      $display("FAIL ls_load: got %0d/%0b want 3/0", busA[2:0], doneA); end
    step(0, 0, 1, 0, 0);
    checks++; if (busA[5:0] !== 6'o33) begin errs++;
      $display("FAIL ls_shift1: got %o want 33", busA[5:0]); end
    checks++; if (doneA !== 1'b1 || cntA !== 6'd1) begin errs++;
      $display("FAIL ls_done1: got %0b/%0d want 1/1", doneA, cntA); end
    step(0, 0, 0, 0, 0);
    checks++; if (doneA !== 1'b0) begin errs++;
      $display("FAIL ls_idle: got %0b want 0", doneA); end
    step(0, 1, 0, 0, 5);
    step(0, 0, 1, 0, 0);
    checks++; if (busA[5:3] !== 3'd5 || busA[8:6] !== 3'd3) begin errs++;
      $display("FAIL ls_shift2: got %0d,%0d want 5,3", busA[5:3], busA[8:6]); end
    checks++; if (busA !== expBusA() || doneA !== 1'b1) begin errs++;
      $display("FAIL ls_model: got %h want %h", busA, expBusA()); end
  endtask

  task automatic test_simultaneous();
    step(0, 1, 0, 0, 2);
    step(0, 1, 1, 0, 7);
    checks++; if (busA[2:0] !== 3'd7 || busA[5:3] !== 3'd2) begin errs++;
      $display("FAIL sim_taps: got %0d,%0d want 7,2", busA[2:0], busA[5:3]); end
    checks++; if (busA !== expBusA()) begin errs++;
      $display("FAIL sim_model: got %h want %h", busA, expBusA()); end
  endtask

  task automatic test_back_to_back();
    step(0, 1, 0, 0, 4);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      checks++; if (doneA !== 1'b1) begin errs++;
        $display("FAIL b2b_done%0d: got %0b want 1", i, doneA); end
    end
    step(0, 0, 0, 0, 0);
    checks++; if (doneA !== 1'b0) begin errs++;
      $display("FAIL b2b_end: got %0b want 0", doneA); end
  endtask

  task automatic test_fill();
    step(0, 0, 0, 1, 0);
    checks++; if (cntA !== '0 || busA !== '0) begin errs++;
      $display("FAIL fill_flush: got %0d want 0", cntA); end
    for (int k = 1; k <= 39; k++) begin
      step(0, 1, 0, 0, k);
      step(0, 0, 1, 0, 0);
      checks++; if (cntA !== 6'(k) || fullA !== (k == 39)) begin errs++;
        $display("FAIL fill_cnt%0d: got %0d/%0b want %0d/%0b",
                 k, cntA, fullA, k, k == 39); end
    end
    step(0, 1, 0, 0, 40);
    checks++; if (busA[119:117] !== 3'd1 || busA[2:0] !== 3'd0) begin errs++;
      $display("FAIL fill_ends: got %0d,%0d want 1,0",
               busA[119:117], busA[2:0]); end
    checks++; if (busA !== expBusA()) begin errs++;
      $display("FAIL fill_model: got %h want %h", busA, expBusA()); end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    checks++; if (cntA !== 6'd39 || fullA !== 1'b1) begin errs++;
      $display("FAIL fill_sat: got %0d/%0b want 39/1", cntA, fullA); end
  endtask

  task automatic test_flush();
    step(0, 1, 1, 1, 6);
    checks++; if (busA !== '0) begin errs++;
      $display("FAIL fl_bus: got %h want 0", busA); end
    checks++; if (cntA !== '0 || fullA !== 1'b0 || doneA !== 1'b0) begin
      errs++;
      $display("FAIL fl_stat: got %0d/%0b/%0b want 0/0/0",
               cntA, fullA, doneA); end
    step(0, 0, 1, 0, 0);
    checks++; if (cntA !== '0 || doneA !== 1'b1) begin errs++;
      $display("FAIL fl_unloaded: got %0d/%0b want 0/1", cntA, doneA); end
    step(0, 1, 0, 0, 4);
    step(0, 0, 1, 0, 0);
    checks++; if (cntA !== 6'd1) begin errs++;
      $display("FAIL fl_restart: got %0d want 1", cntA); end
  endtask

  task automatic test_param();
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 'h80);
    step(1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 'h7F);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    checks++; if (busB[39:32] !== 8'h80 || busB[31:24] !== 8'h7F) begin
      errs++;
      $display("FAIL par_bound: got %h,%h want 80,7f",
               busB[39:32], busB[31:24]); end
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0);
    checks++; if (busB[71:64] !== 8'h80 || busB[63:56] !== 8'h7F) begin
      errs++;
      $display("FAIL par_grp2: got %h,%h want 80,7f",
               busB[71:64], busB[63:56]); end
    checks++; if (busB !== expBusB() || cntB !== 4'd8) begin errs++;
      $display("FAIL par_model: got %h/%0d want %h/8",
               busB, cntB, expBusB()); end
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    checks++; if (cntB !== 4'd11 || fullB !== 1'b1) begin errs++;
      $display("FAIL par_full: got %0d/%0b want 11/1", cntB, fullB); end
  endtask

  task automatic test_random();
    int id, din;
    bit ld, sh, fl;
    for (int i = 0; i < 400; i++) begin
      id  = int'($urandom_range(0, 1));
      ld  = ($urandom % 2) == 0;
      sh  = ($urandom % 3) != 0;
      fl  = ($urandom % 50) == 0;
      din = int'($urandom);
      step(id, ld, sh, fl, din);
      checks++; if (busA !== expBusA()) begin errs++;
        $display("FAIL rnd_busA@%0d: got %h want %h", i, busA, expBusA()); end
      checks++; if (cntA !== 6'(mCnt[0]) || fullA !== expFull(0)) begin
        errs++;
        $display("FAIL rnd_statA@%0d: got %0d/%0b want %0d/%0b",
                 i, cntA, fullA, mCnt[0], expFull(0)); end
      checks++; if (doneA !== mDone[0]) begin errs++;
        $display("FAIL rnd_doneA@%0d: got %0b want %0b", i, doneA, mDone[0]); end
      checks++; if (busB !== expBusB()) begin errs++;
        $display("FAIL rnd_busB@%0d: got %h want %h", i, busB, expBusB()); end
      checks++; if (cntB !== 4'(mCnt[1]) || fullB !== expFull(1)) begin
        errs++;
        $display("FAIL rnd_statB@%0d: got %0d/%0b want %0d/%0b",
                 i, cntB, fullB, mCnt[1], expFull(1)); end
      checks++; if (doneB !== mDone[1]) begin errs++;
        $display("FAIL rnd_doneB@%0d: got %0b want %0b", i, doneB, mDone[1]); end
    end
  endtask

  initial begin
    resetModel();
    test_reset();
    test_load_shift();
    test_simultaneous();
    test_back_to_back();
    test_fill();
    test_flush();
    test_param();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
